// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the RX deserialiser and TX serialiser
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int MIN_BAUD_DIV    = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser, resets to the idle-high line level
module uart_rx_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// rtl/uart_rx_deser.sv - oversampling 8N1 receive deserialiser feeding the RX FIFO
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic                  fifo_full,
    input  logic                  err_clr,
    output logic                  w_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_e             state_q;
    rx_state_e             state_d;
    logic                  rx_s;
    logic                  rx_s_d;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DIV_WIDTH-1:0]  cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shreg;

    logic div_ok;
    logic fall;
    logic start_hit;
    logic bit_hit;
    logic last_bit;
    logic push;
    logic set_frm;
    logic set_ovr;
    logic shift_en;
    logic cnt_clr;
    logic latch_div;

    uart_rx_sync #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s_d <= 1'b1;
        end else begin
            rx_s_d <= rx_s;
        end
    end

    // Start is sampled half a bit in; data and stop bits one full bit after that.
    assign div_ok    = baud_div >= DIV_WIDTH'(MIN_BAUD_DIV);
    assign fall      = !rx_s && rx_s_d;
    assign start_hit = (state_q == START) && (cnt == ((div_q >> 1) - DIV_WIDTH'(1)));
    assign bit_hit   = ((state_q == DATA) || (state_q == STOP)) && (cnt == (div_q - DIV_WIDTH'(1)));
    assign last_bit  = bit_idx == IDX_W'(DATA_WIDTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fall && div_ok) begin
                    state_d = START;
                end
            end
            START: begin
                if (start_hit) begin
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_hit && last_bit) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_hit) begin
                    state_d = rx_s ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = state_q != IDLE;
        push      = (state_q == STOP) && bit_hit && rx_s && !fifo_full;
        set_ovr   = (state_q == STOP) && bit_hit && rx_s && fifo_full;
        set_frm   = (state_q == STOP) && bit_hit && !rx_s;
        shift_en  = (state_q == DATA) && bit_hit;
        cnt_clr   = (state_q == IDLE) || (state_q == WAIT_HIGH) || start_hit || bit_hit;
        latch_div = (state_q == IDLE) && (state_d == START);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (latch_div) begin
                div_q <= baud_div;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_WIDTH'(1);
            end
            if (state_q == START) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end
            // LSB arrives first, so shifting in from the top lands it at bit 0.
            if (shift_en) begin
                shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_en        <= 1'b0;
            data_out    <= '0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            w_en <= push;
            if (push) begin
                data_out <= shreg;
            end
            if (set_frm) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (set_ovr) begin
                overrun_err <= 1'b1;
            end else if (err_clr) begin
                overrun_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb/tb_uart_rx_deser.sv - self-checking bench for uart_rx_deser
module tb_uart_rx_deser;

    localparam int  T = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] baud_div = 16'd16;
    logic        fifo_full = 1'b0;
    logic        err_clr = 1'b0;
    logic        w_en;
    logic [7:0]  data_out;
    logic        frame_err;
    logic        overrun_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q_data[$];
    longint     q_time[$];
    logic [7:0] fq[$];
    bit         fifo_mode = 1'b0;
    bit         force_full = 1'b0;

    uart_rx_deser #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .baud_div    (baud_div),
        .fifo_full   (fifo_full),
        .err_clr     (err_clr),
        .w_en        (w_en),
        .data_out    (data_out),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #(T/2) clk = ~clk;

    // Push recorder plus a 3-entry FIFO model driving fifo_full.
    always @(negedge clk) begin
        if (w_en === 1'b1) begin
            q_data.push_back(data_out);
            q_time.push_back(longint'($time));
            if (fifo_mode) fq.push_back(data_out);
        end
        fifo_full = fifo_mode ? (fq.size() >= 3) : force_full;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    function automatic longint lat(input int n);
        return longint'((3 + n / 2 + 9 * n) * T);
    endfunction

    task automatic idle(input int c);
        rx = 1'b1;
        repeat (c) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int n, input bit stop);
        rx = 1'b0;
        repeat (n) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx = d[k];
            repeat (n) @(negedge clk);
        end
        rx = stop;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({w_en, busy, frame_err, overrun_err} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_flags: got %b, expected 0000", {w_en, busy, frame_err, overrun_err});
        end
        n_checks++;
        if (data_out !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_data: got %0h, expected 0", data_out);
        end
        rst_n = 1'b1;
        idle(4);
    endtask

    task automatic test_single_frame();
        int     base;
        longint t;
        baud_div = 16'd16;
        base = q_data.size();
        t = longint'($time);
        send_frame(8'hA5, 16, 1'b1);
        idle(8);
        n_checks++;
        if (q_data.size() !== base + 1) begin
            n_errors++;
            $display("FAIL single_count: got %0d, expected %0d", q_data.size(), base + 1);
        end else begin
            n_checks++;
            if (q_data[base] !== 8'hA5) begin
                n_errors++;
                $display("FAIL single_data: got %0h, expected a5", q_data[base]);
            end
            n_checks++;
            if (q_time[base] - t !== lat(16)) begin
                n_errors++;
                $display("FAIL single_latency: got %0d, expected %0d", q_time[base] - t, lat(16));
            end
        end
        n_checks++;
        if ({frame_err, overrun_err, busy} !== 3'b000) begin
            n_errors++;
            $display("FAIL single_flags: got %b, expected 000", {frame_err, overrun_err, busy});
        end
    endtask

    task automatic test_glitch();
        int base;
        base = q_data.size();
        rx = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL glitch_busy_high: got %b, expected 1", busy);
        end
        rx = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if ({busy, frame_err, overrun_err} !== 3'b000 || q_data.size() !== base) begin
            n_errors++;
            $display("FAIL glitch_idle: got flags %b pushes %0d, expected 000 pushes %0d",
                     {busy, frame_err, overrun_err}, q_data.size(), base);
        end
        idle(4);
    endtask

    task automatic test_frame_err();
        int base;
        base = q_data.size();
        send_frame(8'h3C, 16, 1'b0);
        rx = 1'b0;
        repeat (40 * 16) @(negedge clk);
        n_checks++;
        if (frame_err !== 1'b1 || q_data.size() !== base || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL break_state: got ferr %b busy %b pushes %0d, expected 1 1 %0d",
                     frame_err, busy, q_data.size(), base);
        end
        idle(32);
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL break_release: got busy %b, expected 0", busy);
        end
        send_frame(8'h55, 16, 1'b1);
        idle(8);
        n_checks++;
        if (q_data.size() !== base + 1 || q_data[base] !== 8'h55) begin
            n_errors++;
            $display("FAIL after_break_data: got %0d pushes last %0h, expected %0d pushes 55",
                     q_data.size(), q_data[q_data.size() - 1], base + 1);
        end
        pulse_clr();
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_errors++;
            $display("FAIL frame_err_clear: got %b, expected 0", frame_err);
        end
    endtask

    task automatic test_overrun();
        int base;
        baud_div = 16'd16;
        force_full = 1'b1;
        idle(2);
        base = q_data.size();
        send_frame(8'h12, 16, 1'b1);
        idle(8);
        n_checks++;
        if (overrun_err !== 1'b1 || frame_err !== 1'b0 || q_data.size() !== base) begin
            n_errors++;
            $display("FAIL overrun_set: got ovr %b ferr %b pushes %0d, expected 1 0 %0d",
                     overrun_err, frame_err, q_data.size(), base);
        end
        pulse_clr();
        n_checks++;
        if (overrun_err !== 1'b0) begin
            n_errors++;
            $display("FAIL overrun_clear: got %b, expected 0", overrun_err);
        end
        fork
            send_frame(8'h34, 16, 1'b1);
            begin
                repeat (2 + 8 + 9 * 16) @(negedge clk);
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
                n_checks++;
                if (overrun_err !== 1'b1) begin
                    n_errors++;
                    $display("FAIL overrun_set_priority: got %b, expected 1", overrun_err);
                end
            end
        join
        idle(8);
        n_checks++;
        if (overrun_err !== 1'b1 || q_data.size() !== base) begin
            n_errors++;
            $display("FAIL overrun_hold: got ovr %b pushes %0d, expected 1 %0d", overrun_err, q_data.size(), base);
        end
        pulse_clr();
        force_full = 1'b0;
        idle(2);
    endtask

    task automatic test_back_to_back();
        int     base;
        longint t;
        fq.delete();
        fifo_mode = 1'b1;
        baud_div = 16'd4;
        idle(4);
        base = q_data.size();
        t = longint'($time);
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 4, 1'b1);
        idle(16);
        n_checks++;
        if (q_data.size() !== base + 3 || overrun_err !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_count: got %0d pushes ovr %b, expected %0d pushes ovr 1",
                     q_data.size(), overrun_err, base + 3);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (fq.size() <= i || fq[i] !== 8'(i + 1) || q_time[base + i] - t !== lat(4) + longint'(i * 40 * T)) begin
                n_errors++;
                $display("FAIL b2b_entry%0d: got data %0h time %0d, expected %0h time %0d",
                         i, (fq.size() > i) ? fq[i] : 8'hxx, q_time[base + i] - t, i + 1,
                         lat(4) + longint'(i * 40 * T));
            end
        end
        fifo_mode = 1'b0;
        fq.delete();
        pulse_clr();
        idle(2);
    endtask

    task automatic test_reset_mid();
        int     base;
        longint t;
        baud_div = 16'd16;
        base = q_data.size();
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (4 * 16 + 8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({w_en, busy, frame_err, overrun_err} !== 4'b0000 || data_out !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_mid_outputs: got flags %b data %0h, expected 0000 data 0",
                     {w_en, busy, frame_err, overrun_err}, data_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(30);
        n_checks++;
        if (q_data.size() !== base) begin
            n_errors++;
            $display("FAIL reset_mid_nopush: got %0d pushes, expected %0d", q_data.size(), base);
        end
        t = longint'($time);
        send_frame(8'h81, 16, 1'b1);
        idle(8);
        n_checks++;
        if (q_data.size() !== base + 1 || q_data[base] !== 8'h81 || q_time[base] - t !== lat(16)) begin
            n_errors++;
            $display("FAIL reset_mid_recover: got %0d pushes data %0h, expected %0d pushes data 81",
                     q_data.size(), q_data[q_data.size() - 1], base + 1);
        end
    endtask

    task automatic test_low_div();
        int base;
        baud_div = 16'd3;
        base = q_data.size();
        rx = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL low_div_busy: got %b, expected 0", busy);
        end
        idle(8);
        n_checks++;
        if (q_data.size() !== base || frame_err !== 1'b0) begin
            n_errors++;
            $display("FAIL low_div_nopush: got %0d pushes ferr %b, expected %0d 0", q_data.size(), frame_err, base);
        end
    endtask

    task automatic test_random();
        int         n;
        int         base;
        logic [7:0] d;
        bit         stop;
        bit         full;
        bit         exp_push;
        bit         exp_ovr;
        bit         exp_frm;
        longint     t;
        for (int i = 0; i < 12; i++) begin
            n    = int'($urandom_range(4, 12));
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            full = ($urandom_range(0, 3) == 0);
            exp_push = stop && !full;
            exp_ovr  = stop && full;
            exp_frm  = !stop;
            baud_div   = 16'(n);
            force_full = full;
            idle(2);
            base = q_data.size();
            t = longint'($time);
            fork
                send_frame(d, n, stop);
                begin
                    repeat (n) @(negedge clk);
                    baud_div = 16'($urandom_range(4, 64));
                end
            join
            idle(2 * n + 4);
            n_checks++;
            if (q_data.size() !== base + int'(exp_push)) begin
                n_errors++;
                $display("FAIL rand%0d_count: got %0d, expected %0d", i, q_data.size(), base + int'(exp_push));
            end else if (exp_push) begin
                n_checks++;
                if (q_data[base] !== d || q_time[base] - t !== lat(n)) begin
                    n_errors++;
                    $display("FAIL rand%0d_data: got %0h at %0d, expected %0h at %0d",
                             i, q_data[base], q_time[base] - t, d, lat(n));
                end
            end
            n_checks++;
            if (frame_err !== exp_frm || overrun_err !== exp_ovr) begin
                n_errors++;
                $display("FAIL rand%0d_flags: got ferr %b ovr %b, expected %b %b",
                         i, frame_err, overrun_err, exp_frm, exp_ovr);
            end
            force_full = 1'b0;
            pulse_clr();
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_low_div();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
